// File: rtl/inst_fetch_pkg.sv
// Shared bus widths, reset level and types for the instruction fetch stage.
// INST_NOP (all zero) decodes as sll $0, so empty slots need no valid qualifier downstream.
package inst_fetch_pkg;

    localparam int ADDR_BUS = 32;
    localparam int INST_BUS = 32;

    localparam logic RST_ENABLE = 1'b0;
    localparam logic [INST_BUS-1:0] INST_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_BUS-1:0] addr;
        logic [INST_BUS-1:0] inst;
    } fetch_pair_t;

    function automatic logic [ADDR_BUS-1:0] word_align(input logic [ADDR_BUS-1:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory request/grant/response handshake.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic                req;
    logic [ADDR_BUS-1:0] addr;
    logic                gnt;
    logic                rvalid;
    logic [INST_BUS-1:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/inst_fetch_fifo2.sv
// Two-entry FIFO used both as the in-flight address tracker and the instruction buffer.
// clr empties the FIFO and wins over a push in the same cycle.
module fifo2
    import inst_fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (clr) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, request credit logic, flush drop accounting, and the
// address tracker / instruction buffer pair that feeds decode one {addr, inst} per cycle.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [ADDR_BUS-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic [ADDR_BUS-1:0] flush_pc,
    inst_fetch_if.master        imem,
    output logic                inst_valid,
    output logic [ADDR_BUS-1:0] addr,
    output logic [INST_BUS-1:0] inst
);

    logic [ADDR_BUS-1:0] pc;
    logic [1:0]          out_cnt;
    logic [1:0]          drop_cnt;
    logic [1:0]          occ;
    logic [2:0]          credit;
    logic                pop;
    logic                grant;
    logic                rsp;
    logic                rsp_keep;
    logic [ADDR_BUS-1:0] trk_addr;
    logic                trk_full;
    logic                trk_empty;
    fetch_pair_t         head;
    logic                buf_full;
    logic                buf_empty;

    assign occ        = {buf_full, ~buf_empty & ~buf_full};
    assign inst_valid = ~buf_empty;
    assign pop        = inst_valid & ~stall;

    // out + occ never exceeds 2, so gating on this credit keeps the buffer from overflowing
    assign credit   = {1'b0, out_cnt} + {1'b0, occ} - {2'b00, pop};
    assign imem.req  = (rst != RST_ENABLE) & ~flush & (credit < 3'd2);
    assign imem.addr = pc;

    assign grant    = imem.req & imem.gnt;
    assign rsp      = imem.rvalid & (out_cnt != 2'd0);
    assign rsp_keep = rsp & (drop_cnt == 2'd0);

    assign addr = inst_valid ? head.addr : '0;
    assign inst = inst_valid ? head.inst : INST_NOP;

    fifo2 #(.WIDTH(ADDR_BUS)) u_trk (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .push  (grant),
        .pop   (rsp),
        .din   (pc),
        .dout  (trk_addr),
        .full  (trk_full),
        .empty (trk_empty)
    );

    fifo2 #(.WIDTH($bits(fetch_pair_t))) u_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (rsp_keep),
        .pop   (pop),
        .din   ({trk_addr, imem.rdata}),
        .dout  (head),
        .full  (buf_full),
        .empty (buf_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            pc       <= RESET_PC;
            out_cnt  <= 2'd0;
            drop_cnt <= 2'd0;
        end else begin
            out_cnt <= out_cnt + {1'b0, grant} - {1'b0, rsp};
            if (flush) begin
                pc       <= word_align(flush_pc);
                // every response still owed after this cycle belongs to the old stream
                drop_cnt <= out_cnt - {1'b0, rsp};
            end else begin
                if (grant) pc <= pc + 32'd4;
                if (rsp && drop_cnt != 2'd0) drop_cnt <= drop_cnt - 2'd1;
            end
        end
    end

    a_rsp_owed: assert property (@(posedge clk) disable iff (rst == RST_ENABLE)
        !(imem.rvalid && out_cnt == 2'd0));

    a_trk_match: assert property (@(posedge clk) disable iff (rst == RST_ENABLE)
        (trk_empty == (out_cnt == 2'd0)) && (trk_full == (out_cnt == 2'd2)));

endmodule

// File: tb/tb_inst_fetch.sv
// Randomised fetch-stage bench: a queue-level model of the fetch stream is compared
// against the DUT every cycle, with directed literal checks for the key scenarios.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        inst_valid;
    logic [31:0] addr;
    logic [31:0] inst;

    inst_fetch_if imem ();

    inst_fetch #(.RESET_PC(RPC)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .imem       (imem),
        .inst_valid (inst_valid),
        .addr       (addr),
        .inst       (inst)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;

    // next-cycle stimulus
    logic        rst_nx = 1'b0;
    logic        stall_nx = 1'b0;
    logic        flush_nx = 1'b0;
    logic [31:0] fpc_nx = '0;
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;

    // reference model: PC, owed responses, addresses in flight, presented queue
    logic [31:0] m_pc;
    int          m_out;
    int          m_drop;
    logic [31:0] m_fly[$];
    logic [63:0] m_buf[$];

    // memory: in-order responses with per-request latency
    typedef struct {
        logic [31:0] a;
        int          due;
    } mreq_t;
    mreq_t mem_q[$];
    int    last_due;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RPC;
        m_out = 0;
        m_drop = 0;
        m_fly.delete();
        m_buf.delete();
        mem_q.delete();
        last_due = 0;
    endtask

    task automatic cyc();
        int          occ;
        bit          pop, exp_req, grant, rv;
        logic [31:0] a;
        int          d;
        @(posedge clk);
        #1;
        cyc_n++;
        rst      = rst_nx;
        stall    = stall_nx;
        flush    = flush_nx;
        flush_pc = fpc_nx;
        imem.gnt = ($urandom_range(99) < gnt_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc_n) begin
            imem.rvalid = 1'b1;
            imem.rdata  = memf(mem_q[0].a);
            void'(mem_q.pop_front());
        end else begin
            imem.rvalid = 1'b0;
            imem.rdata  = $urandom;
        end
        @(negedge clk);
        if (!rst) model_reset();
        occ = m_buf.size();
        pop = (occ > 0) && !stall;
        exp_req = rst && !flush && (m_out + occ - int'(pop) < 2);
        chk("imem_req", imem.req, exp_req);
        chk("imem_addr", imem.addr, m_pc);
        chk("inst_valid", inst_valid, occ > 0);
        chk("addr", addr, occ > 0 ? m_buf[0][63:32] : 32'h0);
        chk("inst", inst, occ > 0 ? m_buf[0][31:0] : 32'h0);
        if (!rst) return;
        if (imem.req && imem.gnt) begin
            d = cyc_n + $urandom_range(lat_max, lat_min);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mem_q.push_back('{imem.addr, d});
        end
        grant = exp_req && imem.gnt;
        rv = imem.rvalid && (m_out > 0);
        a = '0;
        if (rv) a = m_fly.pop_front();
        if (flush) begin
            m_buf.delete();
            m_drop = m_out - int'(rv);
            m_pc = {flush_pc[31:2], 2'b00};
        end else begin
            if (pop) void'(m_buf.pop_front());
            if (rv) begin
                if (m_drop > 0) m_drop--;
                else m_buf.push_back({a, imem.rdata});
            end
            if (grant) begin
                m_fly.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        m_out = m_out + int'(grant) - int'(rv);
    endtask

    task automatic wait_valid(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (inst_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s timeout waiting for inst_valid", nm);
        end
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_req", imem.req, 32'h0);
        chk("arst_imem_addr", imem.addr, RPC);
        chk("arst_valid", inst_valid, 32'h0);
        chk("arst_addr", addr, 32'h0);
        chk("arst_inst", inst, 32'h0);
        model_reset();
        rst_nx = 1'b0;
        stall_nx = 1'b0;
        flush_nx = 1'b0;
        cyc();
        cyc();
        rst_nx = 1'b1;
    endtask

    initial begin
        logic [63:0] hold;
        logic [31:0] hold_pc;
        bit          ok;
        int          n;
        imem.gnt = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata = '0;
        model_reset();

        // reset and streaming from RESET_PC with 1-cycle memory
        cyc();
        cyc();
        chk("rst_req", imem.req, 32'h0);
        chk("rst_valid", inst_valid, 32'h0);
        rst_nx = 1'b1;
        cyc();
        chk("s1_addr0", imem.addr, 32'h0000_0100);
        chk("s1_valid0", inst_valid, 32'h0);
        cyc();
        chk("s1_addr1", imem.addr, 32'h0000_0104);
        chk("s1_valid1", inst_valid, 32'h0);
        cyc();
        chk("s1_addr2", imem.addr, 32'h0000_0108);
        chk("s1_first_addr", addr, 32'h0000_0100);
        chk("s1_first_inst", inst, memf(32'h0000_0100));
        cyc();
        chk("s1_second_addr", addr, 32'h0000_0104);
        for (int i = 0; i < 8; i++) cyc();

        // stall holds the presented pair
        hold = m_buf[0];
        stall_nx = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_addr", addr, hold[63:32]);
            chk("stall_inst", inst, hold[31:0]);
        end
        chk("stall_req_low", imem.req, 32'h0);
        stall_nx = 1'b0;
        cyc();
        chk("rel_addr0", addr, hold[63:32]);
        cyc();
        chk("rel_addr1", addr, hold[63:32] + 32'd4);
        for (int i = 0; i < 5; i++) cyc();

        // grant backpressure
        hold_pc = m_pc;
        gnt_pct = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("bp_addr", imem.addr, hold_pc);
        end
        gnt_pct = 100;
        cyc();
        chk("bp_addr_gnt", imem.addr, hold_pc);
        cyc();
        chk("bp_addr_adv", imem.addr, hold_pc + 32'd4);

        // flush with two requests outstanding, latency 3
        lat_min = 3;
        lat_max = 3;
        n = 0;
        while (m_out != 2 && n < 20) begin
            cyc();
            n++;
        end
        if (m_out != 2) begin
            total++;
            bad++;
            $display("FAIL flush_setup timeout reaching two outstanding");
        end
        flush_nx = 1'b1;
        fpc_nx = 32'h0000_2000;
        cyc();
        flush_nx = 1'b0;
        wait_valid("flush_wait", ok);
        chk("flush_addr", addr, 32'h0000_2000);
        chk("flush_inst", inst, memf(32'h0000_2000));
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 10; i++) cyc();

        // wrap-around
        flush_nx = 1'b1;
        fpc_nx = 32'hFFFF_FFFC;
        cyc();
        flush_nx = 1'b0;
        cyc();
        chk("wrap_addr0", imem.addr, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_addr1", imem.addr, 32'h0000_0000);
        wait_valid("wrap_wait", ok);
        chk("wrap_first", addr, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_next", addr, 32'h0000_0000);
        for (int i = 0; i < 4; i++) cyc();

        // asynchronous reset mid-stream
        mid_reset();
        cyc();
        chk("rr_addr", imem.addr, RPC);
        chk("rr_valid", inst_valid, 32'h0);
        wait_valid("rr_wait", ok);
        chk("rr_first", addr, RPC);

        // randomised traffic
        for (int blk = 0; blk < 15; blk++) begin
            gnt_pct = $urandom_range(100, 30);
            lat_min = 1;
            lat_max = $urandom_range(4, 1);
            for (int i = 0; i < 200; i++) begin
                stall_nx = ($urandom_range(99) < 25);
                flush_nx = ($urandom_range(99) < 3);
                fpc_nx = $urandom;
                if ($urandom_range(999) < 2) mid_reset();
                cyc();
            end
        end
        stall_nx = 1'b0;
        flush_nx = 1'b0;
        for (int i = 0; i < 10; i++) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage. It holds the PC, issues word fetches to instruction memory over a request/grant/response handshake, and buffers up to two returned instructions with their addresses. It presents one `{addr, inst}` pair per cycle to the decode stage, which consumes the `addr`/`inst` pair. Invalid slots are presented as `inst = 32'h0`, which decodes as a NOP (SPECIAL/sll $0), so decode needs no valid-qualification.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset. Asserted when 0 (`RST_ENABLE`).
- `stall` in 1: decode cannot accept this cycle; the presented pair is held.
- `flush` in 1: redirect the fetch stream; has priority over `stall`.
- `flush_pc` in 32: new PC, sampled when `flush`=1.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address, word aligned (`imem_addr[1:0]`=0).
- `imem_gnt` in 1: request accepted this cycle (`imem_req && imem_gnt`).
- `imem_rvalid` in 1: response valid. Responses arrive in order, at least 1 cycle after grant.
- `imem_rdata` in 32: response instruction.
- `inst_valid` out 1: buffer head valid.
- `addr` out 32 (`ADDR_BUS`): address of the presented instruction; 0 when invalid.
- `inst` out 32 (`INST_BUS`): presented instruction; 0 when invalid.

## Operation
- **PC register:** reset value `RESET_PC`. On a grant, `pc <= pc + 4` (wraps modulo 2^32). On `flush`, `pc <= {flush_pc[31:2], 2'b00}`.
- **Outstanding counter** (`out`, 0..2): +1 on grant, −1 on an accepted `imem_rvalid`, net 0 when both occur.
- **Address tracker:** 2-entry FIFO. Pushes `pc` on grant and pops on `imem_rvalid`, so it pairs each response with its address.
- **Instruction buffer** (`occ`, 0..2): 2-entry FIFO of `{addr, inst}`.
  - Push on `imem_rvalid` when `drop` = 0.
  - Pop when `inst_valid && !stall`.
- **Request rule:** `imem_req = !flush && (out + occ − pop) < 2`, where `pop = inst_valid && !stall`.
  - This credit rule guarantees the buffer never overflows.
  - `imem_addr = pc` at all times.
- **Flush:**
  - Instruction buffer is emptied and `inst_valid` = 0 next cycle.
  - `drop <= out − (imem_rvalid ? 1 : 0)`.
  - Address-tracker entries are retained so they can pop on the dropped responses.
  - No request is issued in the flush cycle.
- **Drop counter:** while `drop` > 0, each `imem_rvalid` decrements `drop`, pops the tracker, and discards the data.
- **Protocol error:** `imem_rvalid` while `out` = 0 is ignored and fires a simulation assertion.
- **Reset (async, any time):**
  - `pc` = `RESET_PC`; `out`, `occ`, `drop` = 0.
  - Outputs: `imem_req` = 0, `imem_addr` = `RESET_PC`, `inst_valid` = 0, `addr` = 0, `inst` = 0.
  - After release, `imem_req` asserts on the first clock, since the credit rule allows it.

## Timing
- **Latency:** grant at edge t, response `imem_rvalid` in cycle t+1 at the earliest, `inst_valid` in cycle t+2. There is no bypass from `imem_rdata` to `inst`.
- **Throughput:** 1 instruction/cycle with 1-cycle memory latency, `gnt` tied high and no stall.
- **Stall:** `addr`/`inst` are held stable. Requests continue until `out + occ` = 2, then `imem_req` drops.
- **Granted-cycle hold:** while `imem_req` = 1 and `imem_gnt` = 0, `imem_addr` is held constant.
- **Flush during stall:** `flush` wins; the held pair is discarded.
- **Simultaneous push and pop with occ = 2:** cannot occur, because the credit rule prevents it.

## Structure
- Shared defines: `ADDR_BUS`, `INST_BUS`, `RST_ENABLE` come from the global define header. Add `INST_NOP` (32'h0) there.
- Sub-module `fifo2`:
  - Parameterised-width 2-entry FIFO with push/pop/full/empty.
  - Asynchronous active-low reset.
  - Instantiated twice: address tracker (32 b) and instruction buffer (64 b).
- Top level holds `pc`, `out`, `drop` and the request logic.

## Test plan
1. **Reset streaming:** reset with `RESET_PC`=0x0000_0100; memory with 1-cycle latency, `gnt`=1 → `imem_addr` sequence 0x100, 0x104, 0x108…; `inst_valid` first high 2 cycles after the first grant; one instruction per cycle thereafter, with `addr` matching the data.
2. **Stall:** hold `stall`=1 for 5 cycles mid-stream → `addr`/`inst` unchanged; `imem_req` low once `out + occ` = 2; no instruction lost or duplicated after release.
3. **Flush with outstanding requests:** flush with `flush_pc`=0x0000_2000 while `out`=2 and memory latency is 3 → both stale responses are dropped; the next presented `addr` is 0x2000.
4. **Grant backpressure:** `gnt` low for 4 cycles with `req` high → `imem_addr` stable throughout; PC advances only on grant.
5. **Mid-operation reset:** assert `rst`=0 asynchronously between edges mid-stream → outputs go to their reset values immediately; after release, fetch restarts at `RESET_PC` with no stale data presented.
6. **Wrap-around:** `flush_pc`=0xFFFF_FFFC → fetch addresses 0xFFFF_FFFC, then 0x0000_0000.
